// File: rtl/key_event_pkg.sv
// Shared types and defaults for the key event decoder: FSM state encoding,
// default cycle parameters and the counter-width helper.
package key_event_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PRESSED   = 3'd1,
    ST_LONG_HELD = 3'd2,
    ST_WAIT_GAP  = 3'd3,
    ST_SECOND    = 3'd4
  } key_state_e;

  localparam int unsigned DEF_LONG_CYC   = 32'd1000;
  localparam int unsigned DEF_REPEAT_CYC = 32'd200;
  localparam int unsigned DEF_GAP_CYC    = 32'd300;

  // One spare bit above the largest terminal count keeps compares wrap-free.
  function automatic int unsigned cnt_width(input int unsigned a,
                                            input int unsigned b,
                                            input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m) + 32'd1;
  endfunction

endpackage

// File: rtl/key_event_timer.sv
// Clearable up-counter with a programmable terminal-count compare, shared by
// every state of the key event FSM.
module key_event_timer #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] tc_val,
  output logic         tc_hit
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    if (clr) begin
      cnt_d = {W{1'b0}};
    end else if (en) begin
      cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= {W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_hit = (cnt_q == tc_val);

endmodule

// File: rtl/key_event_decoder.sv
// Turns debounced key activity into short/long/repeat (and optionally double)
// press strobes. Define KEY_DOUBLE_PRESS_EN to compile in double-press detection.
module key_event_decoder
  import key_event_pkg::*;
#(
  parameter int unsigned LONG_CYC   = DEF_LONG_CYC,
  parameter int unsigned REPEAT_CYC = DEF_REPEAT_CYC,
  parameter int unsigned GAP_CYC    = DEF_GAP_CYC
) (
  input  logic clk,
  input  logic reset,
  input  logic stable_flag,
  input  logic press,
  output logic short_press,
  output logic long_press,
  output logic repeat_pulse,
  output logic double_press,
  output logic held
);

  localparam int unsigned CW = cnt_width(LONG_CYC, REPEAT_CYC, GAP_CYC);

  key_state_e    state_q, state_d;
  logic          short_q, short_d;
  logic          long_q, long_d;
  logic          rep_q, rep_d;
  logic          held_q, held_d;
  logic          tmr_clr, tmr_en, tmr_hit;
  logic [CW-1:0] tc_val;
`ifdef KEY_DOUBLE_PRESS_EN
  logic          dbl_q, dbl_d;
`endif

  key_event_timer #(.W(CW)) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clr    (tmr_clr),
    .en     (tmr_en),
    .tc_val (tc_val),
    .tc_hit (tmr_hit)
  );

  always_comb begin
    state_d = state_q;
    short_d = 1'b0;
    long_d  = 1'b0;
    rep_d   = 1'b0;
    tmr_clr = 1'b0;
    tmr_en  = 1'b0;
    tc_val  = {CW{1'b0}};
`ifdef KEY_DOUBLE_PRESS_EN
    dbl_d   = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        tmr_clr = 1'b1;
        if (press) begin
          state_d = ST_PRESSED;
        end else begin
          state_d = ST_IDLE;
        end
      end
      // Release is checked before the long compare so it wins a tie.
      ST_PRESSED: begin
        tc_val = CW'(LONG_CYC - 32'd2);
        if (!stable_flag) begin
          tmr_clr = 1'b1;
`ifdef KEY_DOUBLE_PRESS_EN
          state_d = ST_WAIT_GAP;
`else
          short_d = 1'b1;
          state_d = ST_IDLE;
`endif
        end else if (tmr_hit) begin
          long_d  = 1'b1;
          tmr_clr = 1'b1;
          state_d = ST_LONG_HELD;
        end else begin
          tmr_en = 1'b1;
        end
      end
      ST_LONG_HELD: begin
        tc_val = CW'(REPEAT_CYC - 32'd1);
        if (!stable_flag) begin
          tmr_clr = 1'b1;
          state_d = ST_IDLE;
        end else if (tmr_hit) begin
          rep_d   = 1'b1;
          tmr_clr = 1'b1;
        end else begin
          tmr_en = 1'b1;
        end
      end
`ifdef KEY_DOUBLE_PRESS_EN
      ST_WAIT_GAP: begin
        tc_val = CW'(GAP_CYC - 32'd1);
        if (press) begin
          tmr_clr = 1'b1;
          state_d = ST_SECOND;
        end else if (tmr_hit) begin
          short_d = 1'b1;
          tmr_clr = 1'b1;
          state_d = ST_IDLE;
        end else begin
          tmr_en = 1'b1;
        end
      end
      ST_SECOND: begin
        tmr_clr = 1'b1;
        if (!stable_flag) begin
          dbl_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_SECOND;
        end
      end
`endif
      default: begin
        tmr_clr = 1'b1;
        state_d = ST_IDLE;
      end
    endcase
    held_d = (state_d == ST_PRESSED) || (state_d == ST_LONG_HELD);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      short_q <= 1'b0;
      long_q  <= 1'b0;
      rep_q   <= 1'b0;
      held_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      short_q <= short_d;
      long_q  <= long_d;
      rep_q   <= rep_d;
      held_q  <= held_d;
    end
  end

`ifdef KEY_DOUBLE_PRESS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dbl_q <= 1'b0;
    end else begin
      dbl_q <= dbl_d;
    end
  end

  assign double_press = dbl_q;
`else
  assign double_press = 1'b0;
`endif

  assign short_press  = short_q;
  assign long_press   = long_q;
  assign repeat_pulse = rep_q;
  assign held         = held_q;

endmodule

// File: tb/tb_key_event_decoder.sv
// Directed, table-driven bench for key_event_decoder with LONG=50, REPEAT=20,
// GAP=30; expectations adapt when KEY_DOUBLE_PRESS_EN is defined.
module tb_key_event_decoder;

  localparam int LONG_C = 50;
  localparam int REP_C  = 20;
  localparam int GAP_C  = 30;
`ifdef KEY_DOUBLE_PRESS_EN
  localparam int SD = 1 + GAP_C;
`else
  localparam int SD = 1;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic stable_flag = 1'b0;
  logic press = 1'b0;
  logic short_press, long_press, repeat_pulse, double_press, held;
  logic [4:0] outv;

  int checks = 0;
  int passed = 0;

  key_event_decoder #(
    .LONG_CYC   (LONG_C),
    .REPEAT_CYC (REP_C),
    .GAP_CYC    (GAP_C)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .stable_flag  (stable_flag),
    .press        (press),
    .short_press  (short_press),
    .long_press   (long_press),
    .repeat_pulse (repeat_pulse),
    .double_press (double_press),
    .held         (held)
  );

  always #5 clk = ~clk;

  assign outv = {short_press, long_press, repeat_pulse, double_press, held};

  typedef struct {
    string nm;
    bit    with_press;
    int    hold;
    int    press2;
    int    exp_short;
    int    exp_long;
    int    rep_first;
    int    rep_n;
    int    held_hi;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input logic [4:0] exp, input string nm, input int c);
    checks++;
    if (outv !== exp)
      $display("FAIL %s cyc %0d: got {sh,lg,rp,db,hd}=%b want %b", nm, c, outv, exp);
    else
      passed++;
  endtask

  task automatic step(input logic rs, input logic p, input logic s,
                      input logic [4:0] exp, input string nm, input int c);
    @(posedge clk);
    #1;
    reset = rs;
    press = p;
    stable_flag = s;
    @(negedge clk);
    check(exp, nm, c);
  endtask

  initial begin
    vecs[0] = '{"short20",   1'b1, 20,  -1, 20 + SD, -1, -1, 0, 20};
    vecs[1] = '{"short1",    1'b1, 1,   -1, 1 + SD,  -1, -1, 0, 1};
    vecs[2] = '{"short48",   1'b1, 48,  -1, 48 + SD, -1, -1, 0, 48};
    vecs[3] = '{"rel_on_lg", 1'b1, 49,  -1, 49 + SD, -1, -1, 0, 49};
    vecs[4] = '{"long_rel",  1'b1, 50,  -1, -1,      50, -1, 0, 50};
    vecs[5] = '{"long_rep3", 1'b1, 110, -1, -1,      50, 70, 3, 110};
    vecs[6] = '{"long_rep0", 1'b1, 69,  -1, -1,      50, -1, 0, 69};
    vecs[7] = '{"press_ign", 1'b1, 60,  25, -1,      50, -1, 0, 60};
    vecs[8] = '{"no_press",  1'b0, 60,  -1, -1,      -1, -1, 0, 0};

    // Reset state while reset is held.
    @(negedge clk);
    check(5'b00000, "reset", 0);
    step(1'b0, 1'b0, 1'b0, 5'b00000, "post_reset", 0);
    step(1'b0, 1'b0, 1'b0, 5'b00000, "post_reset", 1);

    for (int v = 0; v < 9; v++) begin
      for (int c = 0; c <= vecs[v].hold + 45; c++) begin
        logic [4:0] e;
        logic p;
        int d;
        p = (vecs[v].with_press && c == 0) || (c == vecs[v].press2);
        d = c - vecs[v].rep_first;
        e[4] = (c == vecs[v].exp_short);
        e[3] = (c == vecs[v].exp_long);
        e[2] = (vecs[v].rep_n > 0) && (d >= 0) && (d % REP_C == 0) && (d / REP_C < vecs[v].rep_n);
        e[1] = 1'b0;
        e[0] = (c >= 1) && (c <= vecs[v].held_hi);
        step(1'b0, p, (c < vecs[v].hold), e, vecs[v].nm, c);
      end
    end

    // Reset during PRESSED with key still held: nothing afterwards.
    for (int c = 0; c <= 80; c++) begin
      logic [4:0] e;
      e = ((c >= 1) && (c <= 29)) ? 5'b00001 : 5'b00000;
      step((c == 30 || c == 31), (c == 0), (c < 65), e, "reset_mid", c);
    end

    // Two presses close together.
    for (int c = 0; c <= 80; c++) begin
      logic [4:0] e;
      e = 5'b00000;
`ifdef KEY_DOUBLE_PRESS_EN
      e[1] = (c == 36);
      e[0] = (c >= 1) && (c <= 10);
`else
      e[4] = (c == 11) || (c == 36);
      e[0] = ((c >= 1) && (c <= 10)) || ((c >= 26) && (c <= 35));
`endif
      step(1'b0, (c == 0 || c == 25), (c < 10 || (c >= 25 && c < 35)), e, "double", c);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/key_event_decoder.md
# key_event_decoder

Classifies debounced key activity into short-press, long-press and auto-repeat events for the water-level controller's setpoint and mode logic. Sits directly downstream of the per-key debounce filter: consumes its `stable_flag` level and one-cycle `press` pulse, and emits one-cycle event strobes to the setpoint/menu controller. Runs on the 1 kHz system tick, so all cycle parameters are milliseconds.

## Interface
- `LONG_CYC`, 1000: stable hold cycles before `long_press` fires; legal range ≥2.
- `REPEAT_CYC`, 200: period of `repeat_pulse` while held after a long press; legal range ≥1.
- `GAP_CYC`, 300: double-press window. Used only with `KEY_DOUBLE_PRESS_EN`; legal range ≥2.
- `clk` input 1: system clock, 1 kHz; all logic rising-edge.
- `reset` input 1: asynchronous, active-high reset.
- `stable_flag` input 1: debounced key level; 1 means pressed.
- `press` input 1: one-cycle pulse on the first cycle of `stable_flag`=1.
- `short_press` output 1: one-cycle strobe for a press released before `LONG_CYC`.
- `long_press` output 1: one-cycle strobe when the hold reaches `LONG_CYC`.
- `repeat_pulse` output 1: one-cycle strobe every `REPEAT_CYC` cycles after `long_press` while held.
- `double_press` output 1: one-cycle strobe for two short presses within `GAP_CYC`. Tied to 0 when the macro is absent.
- `held` output 1: high in PRESSED or LONG_HELD.

## Operation
- States:
  - IDLE
  - PRESSED
  - LONG_HELD
  - WAIT_GAP (macro only)
  - SECOND (macro only)
- One shared counter `cnt`; width is `$clog2` of the largest parameter, plus 1.
- IDLE: `press`=1 → PRESSED, `cnt`=0. `stable_flag` alone never leaves IDLE.
- PRESSED:
  - `stable_flag`=1 and `cnt`==`LONG_CYC`-2 → assert `long_press`, go to LONG_HELD, `cnt`=0.
  - Otherwise, while `stable_flag`=1, `cnt`++.
  - `stable_flag`=0 without macro → assert `short_press`, go to IDLE.
  - `stable_flag`=0 with macro → go to WAIT_GAP, `cnt`=0.
- LONG_HELD:
  - `stable_flag`=0 → IDLE, no strobe.
  - Otherwise `cnt`++; at `cnt`==`REPEAT_CYC`-1 assert `repeat_pulse` and set `cnt`=0.
- WAIT_GAP:
  - `press`=1 → SECOND.
  - Otherwise `cnt`++; at `cnt`==`GAP_CYC`-1 with no press → assert `short_press`, go to IDLE.
- SECOND: `stable_flag`=0 → assert `double_press`, go to IDLE. The second press never produces long or repeat events.
- A `press` outside IDLE and WAIT_GAP is ignored.
- If `stable_flag`=0 and `long_press` would fire in the same cycle, release wins: `short_press` fires, not `long_press`.
- At most one strobe is high in any cycle.

## Timing
- All outputs are registered. Reset value of every output is 0; state resets to IDLE and `cnt` to 0.
- `press` high at edge k → `held`=1 after edge k.
- `long_press` is high for exactly one cycle, `LONG_CYC` cycles after the `press` cycle, provided `stable_flag` stayed 1.
- The first `repeat_pulse` comes `REPEAT_CYC` cycles after `long_press`; subsequent pulses are `REPEAT_CYC` apart.
- `short_press` (no macro) or `double_press` is high the cycle after the first `stable_flag`=0 sample.
- With the macro, `short_press` is delayed by `GAP_CYC` cycles after release.
- Reset asserted mid-operation clears everything immediately. No pending event is emitted after reset deasserts.
- A key still held at reset release is ignored until the next `press`.

## Configuration
- `KEY_DOUBLE_PRESS_EN` defined:
  - WAIT_GAP and SECOND are compiled in.
  - `double_press` is live.
  - `short_press` is deferred by the gap window.
- Absent:
  - Three-state FSM only.
  - `double_press` is constant 0.
  - `short_press` fires immediately on release.
  - `GAP_CYC` is unused.

## Structure
- `key_event_pkg` holds:
  - the state enum
  - default `LONG_CYC`, `REPEAT_CYC` and `GAP_CYC` constants
  - a function computing counter width from the maximum parameter
- Sub-module `key_event_timer`: a clearable up-counter with a programmable terminal-count compare, instantiated once and shared across states.

## Test plan
Bench parameters: `LONG_CYC`=50, `REPEAT_CYC`=20, `GAP_CYC`=30.
- Short press: press at t=10, release at t=30 → `short_press` at t=31 only; `held` high from 11 to 30.
- Long press with repeat: press at t=10, held to t=120 → `long_press` at t=60; `repeat_pulse` at t=80, 100 and 120 (the last only if still held); no `short_press`.
- Release on long boundary: release in exactly the cycle `long_press` would fire → `short_press` only.
- Reset mid-hold: reset at t=40 during PRESSED → all outputs 0; no `long_press` at t=60 even with `stable_flag` still 1.
- Double press (macro): press 10–20, press again at 35, release at 45 → `double_press` at 46; no `short_press`.
- Gap timeout (macro): press 10–20, no second press → `short_press` at 51.
